ode_param_bank: RTL

ODE_PARAM_BANK -- requirements
Module: ode_param_bank

---
 rtl/ode_param_pkg.sv | 23 ++
 rtl/ode_step_div.sv | 46 ++++
 rtl/ode_param_bank.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ode_param_pkg.sv
`default_nettype none
// ============================================================================
// ode_param_pkg : register map offsets, control bits and FSM states
// Rev 1.0
// ============================================================================
package ode_param_pkg;

  // Register offsets relative to CH (the first address after the shadows)
  localparam int unsigned CTRL_OFS   = 0;
  localparam int unsigned PERIOD_OFS = 1;

  localparam int unsigned CTRL_COMMIT = 0;
  localparam int unsigned CTRL_SRST   = 1;
  localparam int unsigned CTRL_RUN    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RST  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ode_step_div.sv
`default_nettype none
// ============================================================================
// ode_step_div : programmable step divider, one-cycle pulse every period+1
// Rev 1.0
// ============================================================================
module ode_step_div #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 49
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             period_we_i,
  input  logic [DIV_W-1:0] period_wdata_i,
  output logic [DIV_W-1:0] period_o,
  output logic             step_o
);

  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] count_q, count_d;

  always_comb begin
    period_d = period_we_i ? period_wdata_i : period_q;
    // A new period restarts the count so the first pulse is a full period away
    if (!en_i || period_we_i || (count_q == period_q)) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= DIV_W'(DEF_DIV);
      count_q  <= '0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

  assign period_o = period_q;
  assign step_o   = en_i && (count_q == period_q);

endmodule
`default_nettype wire

// File: rtl/ode_param_bank.sv
`default_nettype none
// ============================================================================
// ode_param_bank : double-buffered ODE coefficient bank with step-aligned
//                  commit, solver reset pulse and step divider
// Rev 1.0
// ============================================================================
module ode_param_bank
  import ode_param_pkg::*;
#(
  parameter int CH      = 4,
  parameter int W       = 18,
  parameter int DIV_W   = 16,
  parameter int AW      = 4,
  parameter int RST_CYC = 4,
  parameter int DEF_DIV = 49
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   addr,
  input  logic [W-1:0]    wr_data,
  input  logic            rd_en,
  output logic [W-1:0]    rd_data,
  output logic [CH*W-1:0] coef_out,
  output logic            clk_en_out,
  output logic            solver_rst,
  output logic            busy,
  output logic            running
);

  localparam logic [AW-1:0] A_CTRL   = AW'(CH + CTRL_OFS);
  localparam logic [AW-1:0] A_PERIOD = AW'(CH + PERIOD_OFS);
  localparam logic [3:0]    RST_LAST = 4'(RST_CYC - 1);

  state_e                 state_q, state_d;
  logic [3:0]             rst_cnt_q, rst_cnt_d;
  logic                   running_q, running_d;
  logic [CH-1:0][W-1:0]   shadow_q;
  logic [CH-1:0][W-1:0]   active_q;
  logic [W-1:0]           rd_data_q, rd_data_d;
  logic [DIV_W-1:0]       period;
  logic                   step;
  logic                   copy_en;

  logic ctrl_we, period_we, w_commit, w_srst, w_run;

  assign ctrl_we   = wr_en && (addr == A_CTRL);
  assign period_we = wr_en && (addr == A_PERIOD);
  assign w_commit  = wr_data[CTRL_COMMIT];
  assign w_srst    = wr_data[CTRL_SRST];
  assign w_run     = wr_data[CTRL_RUN];

  // FSM: state register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    if (ctrl_we && w_srst) begin
      rst_cnt_d = '0;
    end else if (state_q == ST_RST) begin
      rst_cnt_d = rst_cnt_q + 4'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (ctrl_we && w_srst) state_d = ST_RST;
        else if (ctrl_we && w_commit && w_run) state_d = ST_PEND;
      end
      ST_PEND: begin
        // Without a running divider no step will come, so commit at once
        if (ctrl_we && w_srst) state_d = ST_RST;
        else if (step || !running_q) state_d = ST_IDLE;
      end
      ST_RST: begin
        if (ctrl_we && w_srst) state_d = ST_RST;
        else if (rst_cnt_q == RST_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy       = (state_q == ST_PEND);
    solver_rst = (state_q == ST_RST);
    copy_en    = 1'b0;
    case (state_q)
      ST_IDLE: copy_en = ctrl_we && w_commit && (w_srst || !w_run);
      ST_PEND: copy_en = (ctrl_we && w_srst) || step || !running_q;
      default: copy_en = 1'b0;
    endcase
  end

  always_comb begin
    running_d = ctrl_we ? w_run : running_q;
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < CH; i++) begin
        if (addr == AW'(i)) rd_data_d = active_q[i];
      end
      if (addr == A_CTRL)   rd_data_d = W'({busy, solver_rst, running_q});
      if (addr == A_PERIOD) rd_data_d = W'(period);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      running_q <= 1'b0;
      rd_data_q <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
    end else begin
      running_q <= running_d;
      rd_data_q <= rd_data_d;
      // Copy sees pre-edge shadows, so a same-edge shadow write lands next commit
      for (int i = 0; i < CH; i++) begin
        if (wr_en && (addr == AW'(i))) shadow_q[i] <= wr_data;
        if (copy_en)                   active_q[i] <= shadow_q[i];
      end
    end
  end

  ode_step_div #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) u_step_div (
    .clk            (clk_clk),
    .rst            (reset_reset),
    .en_i           (running_q && (state_q != ST_RST)),
    .period_we_i    (period_we),
    .period_wdata_i (wr_data[DIV_W-1:0]),
    .period_o       (period),
    .step_o         (step)
  );

  assign rd_data    = rd_data_q;
  assign running    = running_q;
  assign coef_out   = active_q;
  assign clk_en_out = step;

endmodule
`default_nettype wire
